audio_dac_serializer: RTL and testbench

Codec-side responder for the sample-write handshake used by the game's sound players. It accepts stereo sample pairs over `write`/`write_ready` into a small FIFO and shifts them out on `AUD_DACDAT` in I2S format. `AUD_BCLK` and `AUD_DACLRCK` are codec-mastered and are treated as asynchronous inputs to the `CLOCK_50` domain. It sits between the audio players and the WM8731 DAC pins.

---
 rtl/audio_dac_serializer.sv | 103 ++++++++++
 tb/tb_audio_dac_serializer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: buffers stereo sample pairs in a small FIFO and shifts them
// out MSB-first in I2S format against codec-mastered BCLK/LRCK.
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata_left,
  input  logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  write_ready,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PAD   = 2'd2;

  logic [1:0]              bclk_sync, lrck_sync;
  logic                    bclk_prev, lrck_prev;
  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count, count_next;
  logic [1:0]              state;
  logic [BW-1:0]           bitcnt;
  logic [DATA_WIDTH-1:0]   shift_reg, right_hold;
  logic                    lrck, bclk_fall, lrck_edge, left_start, right_start;
  logic                    empty, push, pop;

  assign lrck        = lrck_sync[1];
  assign bclk_fall   = bclk_prev & ~bclk_sync[1];
  assign lrck_edge   = bclk_fall & (lrck != lrck_prev);
  assign left_start  = lrck_edge & ~lrck;
  // a right frame is only meaningful once a left frame has been started
  assign right_start = lrck_edge & lrck & (state != IDLE);
  assign empty       = count == '0;
  assign push        = write & write_ready;
  assign pop         = left_start & ~empty;
  assign underflow   = left_start & empty;
  assign count_next  = count + CW'(push) - CW'(pop);

  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], AUD_BCLK};
      lrck_sync <= {lrck_sync[0], AUD_DACLRCK};
      bclk_prev <= bclk_sync[1];
      lrck_prev <= bclk_fall ? lrck : lrck_prev;
    end

  always_ff @(posedge CLOCK_50)
    if (push) mem[wr_ptr] <= {writedata_left, writedata_right};

  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      write_ready <= 1'b1;
    end else begin
      wr_ptr      <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count       <= count_next;
      write_ready <= count_next != CW'(FIFO_DEPTH);
    end

  // frame start only loads; the first data bit leaves on the following BCLK fall
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shift_reg  <= '0;
      right_hold <= '0;
      AUD_DACDAT <= 1'b0;
    end else if (bclk_fall) begin
      if (left_start) begin
        state                   <= SHIFT;
        bitcnt                  <= BW'(DATA_WIDTH);
        {shift_reg, right_hold} <= empty ? '0 : mem[rd_ptr];
      end else if (right_start) begin
        state     <= SHIFT;
        bitcnt    <= BW'(DATA_WIDTH);
        shift_reg <= right_hold;
      end else if (state == SHIFT && bitcnt != '0) begin
        AUD_DACDAT <= shift_reg[DATA_WIDTH-1];
        shift_reg  <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
        bitcnt     <= bitcnt - 1'b1;
      end else begin
        state      <= state == SHIFT ? PAD : state;
        AUD_DACDAT <= 1'b0;
      end
    end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: codec model driving BCLK/LRCK, scoreboard of pushed pairs
// checked bit by bit at BCLK rising edges.
module tb_audio_dac_serializer;
  localparam int W = 24;
  logic CLOCK_50 = 1'b0, reset = 1'b0, write = 1'b0;
  logic AUD_BCLK = 1'b1, AUD_DACLRCK = 1'b1;
  logic write_ready, AUD_DACDAT, underflow;
  logic [W-1:0] data_l = '0, data_r = '0;
  logic [W-1:0] cur_l = '0, cur_r = '0;
  logic [2*W-1:0] sb [$];
  logic act = 1'b0, frames_on = 1'b0, eb;
  int div = 0, pos = 63;
  int frame_cnt = 0, uf_cnt = 0, exp_uf = 0;
  int passes = 0, fails = 0, total = 0;

  audio_dac_serializer #(.DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .write(write),
    .writedata_left(data_l), .writedata_right(data_r), .write_ready(write_ready),
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
    .underflow(underflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // codec: BCLK half period of 4 CLOCK_50 cycles, 64 BCLK per frame, LRCK moves on BCLK fall
  always @(negedge CLOCK_50) begin
    div <= (div == 3) ? 0 : div + 1;
    if (div == 3) begin
      AUD_BCLK <= ~AUD_BCLK;
      if (AUD_BCLK) begin
        act         <= frames_on;
        pos         <= frames_on ? (pos + 1) % 64 : 63;
        AUD_DACLRCK <= frames_on ? ((pos + 1) % 64 >= 32) : 1'b1;
      end
    end
  end

  always @(posedge AUD_BCLK)
    if (act) begin
      if (pos == 0) begin
        if (sb.size() != 0) {cur_l, cur_r} = sb.pop_front();
        else begin
          cur_l = '0;
          cur_r = '0;
          exp_uf++;
        end
      end
      eb = (pos >= 1 && pos <= 24) ? cur_l[5'(24 - pos)] :
           (pos >= 33 && pos <= 56) ? cur_r[5'(56 - pos)] : 1'b0;
      check($sformatf("bit_pos%0d", pos), 32'(AUD_DACDAT), 32'(eb));
      if (pos == 63) frame_cnt++;
    end

  always @(negedge CLOCK_50)
    if (underflow === 1'b1) uf_cnt++;

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    check("push_ready", 32'(write_ready), 32'(sb.size() < 4));
    data_l = l;
    data_r = r;
    write = 1'b1;
    if (sb.size() < 4) sb.push_back({l, r});
    @(negedge CLOCK_50);
    write = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 4000 && frame_cnt < target; i++) @(negedge CLOCK_50);
    check("frame_wait", 32'(frame_cnt >= target), 32'd1);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 2000 && !(act && pos == p); i++) @(negedge CLOCK_50);
    check("pos_wait", 32'(act && pos == p), 32'd1);
  endtask

  initial begin
    repeat (20) @(negedge CLOCK_50);
    check("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
    check("rst_ready", 32'(write_ready), 32'd1);
    check("rst_underflow", 32'(underflow), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (30) @(negedge CLOCK_50);
      check("idle_dacdat", 32'(AUD_DACDAT), 32'd0);
    end
    check("idle_ready", 32'(write_ready), 32'd1);

    push(24'hA50F3C, 24'h800001);
    frames_on = 1'b1;
    wait_frames(1);
    frames_on = 1'b0;
    check("single_underflow", 32'(uf_cnt), 32'(exp_uf));

    repeat (20) @(negedge CLOCK_50);
    for (int i = 1; i <= 5; i++) push(24'(24'h111111 * i), 24'(~(24'h111111 * i)));
    check("full_ready", 32'(write_ready), 32'd0);
    frames_on = 1'b1;
    wait_pos(2);
    check("after_pop_ready", 32'(write_ready), 32'd1);
    wait_frames(3);

    // third frame start: push lands on the same CLOCK_50 cycle as the left-frame pop
    wait_pos(0);
    @(negedge CLOCK_50);
    push(24'h5EC0DE, 24'h0FACE1);
    check("same_cycle_ready", 32'(write_ready), 32'd1);
    wait_frames(8);
    frames_on = 1'b0;
    check("underflow_count", 32'(uf_cnt), 32'(exp_uf));
    check("drained_ready", 32'(write_ready), 32'd1);

    repeat (20) @(negedge CLOCK_50);
    push(24'h3CC3A5, 24'h123456);
    frames_on = 1'b1;
    wait_pos(10);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    sb.delete();
    cur_l = '0;
    cur_r = '0;
    #1;
    check("midrst_dacdat", 32'(AUD_DACDAT), 32'd0);
    check("midrst_ready", 32'(write_ready), 32'd1);
    repeat (5) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    push(24'h0C0FFE, 24'h000001);
    wait_frames(10);
    frames_on = 1'b0;
    check("final_underflow", 32'(uf_cnt), 32'(exp_uf));
    repeat (20) @(negedge CLOCK_50);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
